approx_booth_mult_pipe: RTL and testbench
=========================================

Name: approx_booth_mult_pipe

Overview:
- Parametrised successor to the fixed 16-bit registered approximate radix-4 Booth multiplier wrapper.
- Generic operand width, configurable approximation depth, and a configurable pipeline depth.
- valid/ready handshakes on input and output; a tag passes through alongside each product.
- Sits between operand producers and accumulators in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand width in bits (even, >=4); product is 2*WIDTH bits.
- APPROX_P, 14, number of low product columns dropped from every Booth partial product (0 = exact, max 2*WIDTH).
- STAGES, 2, number of pipeline register stages (>=1); equals latency with no stall.
- TAG_W, 4, width of the passthrough tag (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- x  in  WIDTH  signed multiplicand (two's complement)
- y  in  WIDTH  signed multiplier (two's complement)
- in_tag  in  TAG_W  user tag, returned with the product
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts the product
- p_out  out  2*WIDTH  approximate signed product
- out_tag  out  TAG_W  tag of the product on p_out

Behaviour:
- Reset: clk and a single asynchronous active-low rst_n; while rst_n=0, all stage valid bits, out_valid, p_out and out_tag are 0.
- After reset, in_ready is 1 on the first cycle.
- Reset asserted mid-operation discards all in-flight data immediately; no partial outputs follow.
- Arithmetic: radix-4 Booth, WIDTH/2 digits, d_i = -2*y[2i+1] + y[2i] + y[2i-1], with y[-1]=0 and d_i in {-2..2}.
- pp_i = d_i * sext(x) * 4^i, formed as an exact 2*WIDTH-bit two's-complement value; negation is an exact two's complement, with no separate correction bits.
- Bits [APPROX_P-1:0] of each pp_i are forced to 0.
- p_out = sum of masked pp_i mod 2^(2*WIDTH).
- With APPROX_P=0 the result equals the exact signed product.
- Pipeline: stage k holds valid_k, data and tag.
- ready_k = !valid_k || ready_(k+1); ready_STAGES = out_ready.
- in_ready = ready_0, combinational; no combinational path from in_valid to in_ready.
- Stage 0 loads on in_valid && in_ready. A stage loads from its predecessor when it is ready; a valid stage with ready=0 holds its data and tag unchanged.
- Bubbles collapse, giving full throughput of one result per cycle when out_ready=1.
- Latency is exactly STAGES cycles from acceptance to out_valid with no stall.
- Output is the last stage: out_valid = valid_(STAGES-1).
- p_out and out_tag are stable while out_valid && !out_ready.
- A transfer happens on out_valid && out_ready.
- Results leave in strict acceptance order. Capacity is STAGES items; with all stages full and out_ready=0, in_ready=0.
- Simultaneous output pop and input push when full: both occur in the same cycle, and occupancy is unchanged.
- The partial-product reduction may be split across stages freely. Only the registered boundary behaviour above is normative.

Optional Feature:
- Macro: APPROX_MULT_COMP_EN.
- Defined, and APPROX_P>0: the constant 2^(APPROX_P-1) is added to the masked sum before the final register (mod 2^(2*WIDTH)). This is mean-error compensation, and latency is unchanged.
- Defined with APPROX_P=0: no addition.
- Not defined: no compensation logic is present.

Test Plan:
- Defaults (WIDTH=16, APPROX_P=14, STAGES=2), macro off: x=0x00FF, y=0x0003, tag=5 -> two cycles later p_out=0xFFFFC000, out_tag=5, out_valid high for 1 cycle with out_ready=1.
- Same stimulus, APPROX_MULT_COMP_EN defined -> p_out=0xFFFFE000. Same stimulus, APPROX_P=0 -> p_out=0x000002FD (765).
- APPROX_P=0: x=0xFFFF, y=0xFFFF -> p_out=0x00000001; x=0x8000, y=0x8000 -> p_out=0x40000000; back-to-back issue yields results on consecutive cycles.
- STAGES=3, out_ready=0, in_valid held with 5 tagged operands -> exactly 3 accepted, in_ready=0 after, p_out/out_tag frozen; then out_ready=1 -> all 5 results emerge in tag order, none duplicated or lost.
- Random out_ready toggling, 1000 random operands, APPROX_P in {0, 6, 14} -> every output matches the masked-Booth reference model with tags in order.
- rst_n pulled low for 1 cycle with 2 items in flight -> out_valid=0 and p_out=0 immediately; after release, no stale outputs appear and in_ready=1.

Source files
------------

// File: rtl/approx_booth_mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : approx_booth_mult_pipe                                       |
// | Description : Approximate radix-4 Booth multiplier with a valid/ready      |
// |               pipeline and tag passthrough. Optional macro                 |
// |               APPROX_MULT_COMP_EN adds mean-error compensation.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module approx_booth_mult_pipe #(
  parameter int WIDTH    = 16,
  parameter int APPROX_P = 14,
  parameter int STAGES   = 2,
  parameter int TAG_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p_out,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int c_PW     = 2 * WIDTH;
  localparam int c_DIGITS = WIDTH / 2;

  localparam logic [c_PW-1:0] c_ONE    = {{(c_PW-1){1'b0}}, 1'b1};
  localparam logic [c_PW:0]   c_ONE_SH = {{c_PW{1'b0}}, 1'b1} << APPROX_P;
  // Keeps columns [2*WIDTH-1:APPROX_P]; all-zero when every column is dropped.
  localparam logic [c_PW-1:0] c_KEEP   = ~(c_ONE_SH[c_PW-1:0] - c_ONE);
`ifdef APPROX_MULT_COMP_EN
  // 2^(APPROX_P-1), or zero when APPROX_P is zero.
  localparam logic [c_PW-1:0] c_COMP   = c_ONE_SH[c_PW:1];
`endif

  logic [WIDTH:0]    w_ypad;
  logic [c_PW-1:0]   w_xs;
  logic [c_PW-1:0]   w_pp [c_DIGITS];
  logic [c_PW-1:0]   w_sum;
  logic [c_PW-1:0]   w_result;

  assign w_ypad = {y, 1'b0};
  assign w_xs   = {{WIDTH{x[WIDTH-1]}}, x};

  genvar gi;
  generate
    for (gi = 0; gi < c_DIGITS; gi++) begin : g_pp
      logic [2:0]      w_trip;
      logic [c_PW-1:0] w_mag;
      logic [c_PW-1:0] w_sgn;

      assign w_trip = w_ypad[2*gi +: 3];

      // Digit magnitude selects x or 2x; the top bit of the triplet is the sign.
      always_comb begin
        w_mag = '0;
        case (w_trip)
          3'b001, 3'b010, 3'b101, 3'b110: w_mag = w_xs;
          3'b011, 3'b100:                 w_mag = {w_xs[c_PW-2:0], 1'b0};
          default:                        w_mag = '0;
        endcase
        w_sgn = w_trip[2] ? (~w_mag + c_ONE) : w_mag;
      end

      assign w_pp[gi] = (w_sgn << (2*gi)) & c_KEEP;
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < c_DIGITS; i++) begin
      w_sum = w_sum + w_pp[i];
    end
  end

`ifdef APPROX_MULT_COMP_EN
  assign w_result = w_sum + c_COMP;
`else
  assign w_result = w_sum;
`endif

  logic [STAGES-1:0] r_valid;
  logic [c_PW-1:0]   r_data [STAGES];
  logic [TAG_W-1:0]  r_tag  [STAGES];
  logic [STAGES:0]   w_ready;

  // A stage can take new data when empty or when its successor drains it.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = ~r_valid[k] | w_ready[k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
        r_tag[k]  <= '0;
      end
    end else begin
      if (w_ready[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_result;
          r_tag[0]  <= in_tag;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_data[k] <= r_data[k-1];
            r_tag[k]  <= r_tag[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[STAGES-1];
  assign p_out     = r_data[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_approx_booth_mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_approx_booth_mult_pipe                                    |
// | Description : Scoreboard bench for approx_booth_mult_pipe over three       |
// |               parameter sets (APPROX_P 14/0/6, STAGES 2/3/1).              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_approx_booth_mult_pipe;

  localparam int N = 3;
`ifdef APPROX_MULT_COMP_EN
  localparam logic [31:0] COMP14 = 32'h0000_2000;
`else
  localparam logic [31:0] COMP14 = 32'h0000_0000;
`endif

  typedef struct {
    logic [31:0] p;
    logic [3:0]  tag;
    int          cyc;
  } ent_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  tag;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } tv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] x_d;
  logic [15:0] y_d;
  logic [3:0]  tag_d;

  logic        in_ready_v  [N];
  logic        out_valid_v [N];
  logic [31:0] p_out_v     [N];
  logic [3:0]  out_tag_v   [N];

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      approx_booth_mult_pipe #(
        .WIDTH    (16),
        .APPROX_P ((g == 0) ? 14 : ((g == 1) ? 0 : 6)),
        .STAGES   ((g == 1) ? 3 : ((g == 2) ? 1 : 2)),
        .TAG_W    (4)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_v[g]),
        .x         (x_d),
        .y         (y_d),
        .in_tag    (tag_d),
        .out_valid (out_valid_v[g]),
        .out_ready (out_ready),
        .p_out     (p_out_v[g]),
        .out_tag   (out_tag_v[g])
      );
    end
  endgenerate

  function automatic int p_of(int i);
    return (i == 0) ? 14 : ((i == 1) ? 0 : 6);
  endfunction

  function automatic int s_of(int i);
    return (i == 1) ? 3 : ((i == 2) ? 1 : 2);
  endfunction

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;
  bit   use_tab = 1'b0;
  logic [31:0] tab_e [N];
  int   acc_cnt [N];
  ent_t q0[$];
  ent_t q1[$];
  ent_t q2[$];
  tv_t  tab [8];

  always @(posedge clk) cyc <= cyc + 1;

  // Masked radix-4 Booth sum computed straight from the digit formula.
  function automatic logic [31:0] booth_ref(logic [15:0] a, logic [15:0] b, int p);
    longint      sx;
    longint      pp;
    logic [16:0] bp;
    logic [31:0] keep;
    logic [31:0] acc;
    logic [31:0] ppl;
    int          d;
    int          b2;
    int          b1;
    int          b0;
    sx   = longint'($signed(a));
    bp   = {b, 1'b0};
    keep = (p >= 32) ? 32'h0 : ~((32'h1 << p) - 32'h1);
    acc  = '0;
    for (int i = 0; i < 8; i++) begin
      b2  = int'(bp[2*i+2]);
      b1  = int'(bp[2*i+1]);
      b0  = int'(bp[2*i]);
      d   = -2 * b2 + b1 + b0;
      pp  = longint'(d) * sx * (longint'(1) << (2 * i));
      ppl = pp[31:0];
      acc = acc + (ppl & keep);
    end
`ifdef APPROX_MULT_COMP_EN
    if (p > 0) acc = acc + (32'h1 << (p - 1));
`endif
    return acc;
  endfunction

  function automatic logic [31:0] expect_of(int i, logic [15:0] a, logic [15:0] b);
    longint prod;
    if (p_of(i) == 0) begin
      prod = longint'($signed(a)) * longint'($signed(b));
      return prod[31:0];
    end
    return booth_ref(a, b, p_of(i));
  endfunction

  function automatic int qsize(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ent_t qfront(int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(int i, ent_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; resolves the
  // handshakes of the coming rising edge, then waits for the next falling edge.
  task automatic step();
    ent_t e;
    #1;
    for (int i = 0; i < N; i++) begin
      if (out_valid_v[i] === 1'b1) begin
        if (qsize(i) == 0) begin
          chk($sformatf("spurious_out%0d", i), {31'b0, out_valid_v[i]}, 32'd0);
        end else begin
          e = qfront(i);
          chk($sformatf("p_out%0d", i), p_out_v[i], e.p);
          chk($sformatf("out_tag%0d", i), {28'b0, out_tag_v[i]}, {28'b0, e.tag});
          if (out_ready) begin
            if (chk_lat) chk($sformatf("latency%0d", i), cyc - e.cyc, s_of(i));
            qpop(i);
          end
        end
      end
      if (in_valid && in_ready_v[i]) begin
        e.p   = use_tab ? tab_e[i] : expect_of(i, x_d, y_d);
        e.tag = tag_d;
        e.cyc = cyc;
        qpush(i, e);
        acc_cnt[i]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(int budget);
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((qsize(0) + qsize(1) + qsize(2)) != 0 && n < budget) begin
      step();
      n++;
    end
    for (int i = 0; i < N; i++) chk($sformatf("drain_left%0d", i), qsize(i), 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_out_valid%0d", tag, i), {31'b0, out_valid_v[i]}, 32'd0);
      chk($sformatf("%s_p_out%0d", tag, i), p_out_v[i], 32'd0);
      chk($sformatf("%s_out_tag%0d", tag, i), {28'b0, out_tag_v[i]}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x_d = '0; y_d = '0; tag_d = '0;
    for (int i = 0; i < N; i++) begin acc_cnt[i] = 0; tab_e[i] = '0; end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("in_ready_after_reset%0d", i), {31'b0, in_ready_v[i]}, 32'd1);
    @(negedge clk);

    // Directed vectors, issued back to back with the consumer always ready.
    tab[0] = '{16'h00FF, 16'h0003, 4'd5, 32'hFFFF_C000 + COMP14, 32'h0000_02FD, 32'h0};
    tab[1] = '{16'hFFFF, 16'hFFFF, 4'd6, 32'h0000_0000 + COMP14, 32'h0000_0001, 32'h0};
    tab[2] = '{16'h8000, 16'h8000, 4'd7, 32'h4000_0000 + COMP14, 32'h4000_0000, 32'h0};
    tab[3] = '{16'h7FFF, 16'h7FFF, 4'd8, 32'h0, 32'h0, 32'h0};
    tab[4] = '{16'h1234, 16'h0000, 4'd9, 32'h0, 32'h0, 32'h0};
    tab[5] = '{16'h8000, 16'h7FFF, 4'd10, 32'h0, 32'h0, 32'h0};
    tab[6] = '{16'hABCD, 16'h5678, 4'd11, 32'h0, 32'h0, 32'h0};
    tab[7] = '{16'h0001, 16'hFFFF, 4'd12, 32'h0, 32'h0, 32'h0};
    for (int k = 0; k < 8; k++) begin
      if (k >= 3) begin
        tab[k].e0 = expect_of(0, tab[k].x, tab[k].y);
        tab[k].e1 = expect_of(1, tab[k].x, tab[k].y);
      end
      tab[k].e2 = expect_of(2, tab[k].x, tab[k].y);
    end
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    out_ready = 1'b1; chk_lat = 1'b1; use_tab = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      x_d = tab[k].x; y_d = tab[k].y; tag_d = tab[k].tag;
      tab_e[0] = tab[k].e0; tab_e[1] = tab[k].e1; tab_e[2] = tab[k].e2;
      step();
    end
    use_tab = 1'b0;
    for (int i = 0; i < N; i++) chk($sformatf("throughput_accepts%0d", i), acc_cnt[i], 32'd8);
    drain(20);
    chk_lat = 1'b0;

    // Backpressure: five operands offered, held until the STAGES=3 copy takes each.
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      x_d   = 16'(16'h1357 * (acc_cnt[1] + 1));
      y_d   = 16'(16'hF0F1 + acc_cnt[1]);
      tag_d = 4'(acc_cnt[1]);
      step();
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("stall_accepts%0d", i), acc_cnt[i], s_of(i));
      chk($sformatf("stall_in_ready%0d", i), {31'b0, in_ready_v[i]}, 32'd0);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && acc_cnt[1] < 5; c++) begin
      in_valid = 1'b1;
      x_d   = 16'(16'h1357 * (acc_cnt[1] + 1));
      y_d   = 16'(16'hF0F1 + acc_cnt[1]);
      tag_d = 4'(acc_cnt[1]);
      step();
    end
    chk("stall_total_accepts1", acc_cnt[1], 32'd5);
    drain(20);

    // Reset with items in flight must discard them.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      x_d = 16'h4321 + 16'(c); y_d = 16'h00F0; tag_d = 4'(c + 3);
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    q0.delete(); q1.delete(); q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("in_ready_after_midreset%0d", i), {31'b0, in_ready_v[i]}, 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      for (int i = 0; i < N; i++) chk($sformatf("no_stale_out%0d", i), {31'b0, out_valid_v[i]}, 32'd0);
    end

    // Random operands under random consumer backpressure.
    for (int c = 0; c < 1000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(1) != 0);
      x_d   = 16'($urandom);
      y_d   = 16'($urandom);
      tag_d = 4'($urandom);
      step();
    end
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
